// File: rtl/stream_sink_checker.sv
// Stream sink that applies a selectable ready backpressure policy and checks
// that accepted words form an incrementing sequence, counting beats and mismatches.
module stream_sink_checker #(
    parameter int                   DATA_SIZE   = 8,
    parameter logic [DATA_SIZE-1:0] START_VALUE = '0,
    parameter logic [15:0]          LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_clk_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [1:0]           ready_mode_i,
    input  logic                 clear_i,
    output logic [31:0]          beat_cnt_o,
    output logic [15:0]          err_cnt_o,
    output logic                 err_o,
    output logic [DATA_SIZE-1:0] first_err_data_o,
    output logic [DATA_SIZE-1:0] first_err_exp_o
);

    // Handshake: a word transfers on a rising edge where data_valid_i and
    // data_ready_o are both high; ready is a register and never looks at valid.

    localparam logic [1:0] MODE_ALWAYS = 2'd0;
    localparam logic [1:0] MODE_NEVER  = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;

    logic [15:0]          lfsr_q;
    logic                 lfsr_fb;
    logic                 ready_next;
    logic [DATA_SIZE-1:0] exp_q;
    logic                 accept;
    logic                 mismatch;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign accept   = data_valid_i & data_ready_o;
    assign mismatch = accept & (data_i != exp_q);

    always_comb begin
        ready_next = 1'b0;
        case (ready_mode_i)
            MODE_ALWAYS: ready_next = 1'b1;
            MODE_NEVER:  ready_next = 1'b0;
            MODE_LFSR:   ready_next = lfsr_q[0];
            default:     ready_next = ~data_ready_o;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            lfsr_q       <= LFSR_SEED;
            data_ready_o <= 1'b0;
        end else begin
            lfsr_q       <= {lfsr_fb, lfsr_q[15:1]};
            data_ready_o <= ready_next;
        end
    end

    // Clear takes priority over a beat accepted in the same cycle.
    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            exp_q            <= START_VALUE;
            beat_cnt_o       <= '0;
            err_cnt_o        <= '0;
            err_o            <= 1'b0;
            first_err_data_o <= '0;
            first_err_exp_o  <= '0;
        end else if (clear_i) begin
            exp_q            <= START_VALUE;
            beat_cnt_o       <= '0;
            err_cnt_o        <= '0;
            err_o            <= 1'b0;
            first_err_data_o <= '0;
            first_err_exp_o  <= '0;
        end else if (accept) begin
            // Resync on the received word so a jump costs a single error.
            exp_q <= data_i + DATA_SIZE'(1);
            if (beat_cnt_o != 32'hFFFF_FFFF) begin
                beat_cnt_o <= beat_cnt_o + 32'd1;
            end
            if (mismatch) begin
                err_o <= 1'b1;
                if (err_cnt_o != 16'hFFFF) begin
                    err_cnt_o <= err_cnt_o + 16'd1;
                end
                if (!err_o) begin
                    first_err_data_o <= data_i;
                    first_err_exp_o  <= exp_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Randomized bench for stream_sink_checker: a word-level scoreboard predicts
// ready, counters and first-error capture from the accepted-word history.
module tb_stream_sink_checker;

    localparam int         W     = 8;
    localparam logic [W-1:0] START = 8'h00;
    localparam logic [15:0]  SEED  = 16'hACE1;

    logic         clk_i = 1'b0;
    logic         rst_clk_i = 1'b1;
    logic [W-1:0] data_i = '0;
    logic         data_valid_i = 1'b0;
    logic         data_ready_o;
    logic [1:0]   ready_mode_i = 2'd0;
    logic         clear_i = 1'b0;
    logic [31:0]  beat_cnt_o;
    logic [15:0]  err_cnt_o;
    logic         err_o;
    logic [W-1:0] first_err_data_o;
    logic [W-1:0] first_err_exp_o;

    stream_sink_checker #(
        .DATA_SIZE(W),
        .START_VALUE(START),
        .LFSR_SEED(SEED)
    ) dut (
        .clk_i(clk_i),
        .rst_clk_i(rst_clk_i),
        .data_i(data_i),
        .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o),
        .ready_mode_i(ready_mode_i),
        .clear_i(clear_i),
        .beat_cnt_o(beat_cnt_o),
        .err_cnt_o(err_cnt_o),
        .err_o(err_o),
        .first_err_data_o(first_err_data_o),
        .first_err_exp_o(first_err_exp_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // scoreboard: accepted words since the last clear or reset
    logic [W-1:0] exp_q[$];
    logic         m_ready;
    logic [15:0]  m_lfsr;
    int unsigned  m_beats;
    int unsigned  m_errs;
    logic         m_err;
    logic [W-1:0] m_fd;
    logic [W-1:0] m_fe;
    logic [W-1:0] nxt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] bit_in;
        bit_in = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
        return (v >> 1) | (bit_in << 15);
    endfunction

    function automatic logic [W-1:0] want_word();
        logic [W-1:0] last;
        if (exp_q.size() == 0) return START;
        last = exp_q[$];
        return last + W'(1);
    endfunction

    task automatic sb_clear_stats();
        exp_q.delete();
        m_beats = 0;
        m_errs  = 0;
        m_err   = 1'b0;
        m_fd    = '0;
        m_fe    = '0;
    endtask

    task automatic sb_reset();
        sb_clear_stats();
        m_ready = 1'b0;
        m_lfsr  = SEED;
    endtask

    task automatic sb_push(input logic [W-1:0] d);
        logic [W-1:0] w;
        w = want_word();
        if (d != w) begin
            if (m_errs < 32'hFFFF) m_errs++;
            if (!m_err) begin
                m_fd = d;
                m_fe = w;
            end
            m_err = 1'b1;
        end
        if (m_beats != 32'hFFFF_FFFF) m_beats++;
        exp_q.push_back(d);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"}, 32'(data_ready_o), 32'(m_ready));
        check({tag, ".beats"}, beat_cnt_o, m_beats);
        check({tag, ".errs"}, 32'(err_cnt_o), m_errs);
        check({tag, ".err"}, 32'(err_o), 32'(m_err));
        check({tag, ".fdata"}, 32'(first_err_data_o), 32'(m_fd));
        check({tag, ".fexp"}, 32'(first_err_exp_o), 32'(m_fe));
    endtask

    // driver: one clock cycle, entered and left at a falling edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic clr, output logic acc);
        logic nr;
        data_valid_i = v;
        data_i       = d;
        clear_i      = clr;
        @(posedge clk_i);
        acc = v && m_ready;
        if (clr) sb_clear_stats();
        else if (acc) sb_push(d);
        case (ready_mode_i)
            2'd0:    nr = 1'b1;
            2'd1:    nr = 1'b0;
            2'd2:    nr = m_lfsr[0];
            default: nr = !m_ready;
        endcase
        m_ready = nr;
        m_lfsr  = lfsr_step(m_lfsr);
        @(negedge clk_i);
        check_all("cyc");
    endtask

    task automatic send_word(input logic [W-1:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            step(1'b1, d, 1'b0, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        nxt = d + W'(1);
    endtask

    task automatic do_clear();
        logic acc;
        step(1'b0, '0, 1'b1, acc);
        nxt = START;
    endtask

    task automatic run(input int n, input int vpct, input int errpct, input int clrpct);
        logic         acc;
        logic         v;
        logic         clr;
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            v   = ($urandom_range(99) < vpct);
            clr = ($urandom_range(99) < clrpct);
            d   = nxt;
            if ($urandom_range(99) < errpct) d = nxt ^ W'($urandom_range(255, 1));
            step(v, d, clr, acc);
            if (clr) nxt = START;
            else if (acc) nxt = d + W'(1);
        end
    endtask

    initial begin
        logic acc;
        sb_reset();
        nxt = START;
        repeat (3) @(negedge clk_i);
        check_all("reset");
        rst_clk_i = 1'b0;

        // full 0x00..0xFF sweep then wrap to 0x00
        ready_mode_i = 2'd0;
        for (int i = 0; i < 256; i++) send_word(W'(i));
        send_word(8'h00);
        check("sweep.beats", beat_cnt_o, 32'd257);
        check("sweep.errs", 32'(err_cnt_o), 32'd0);
        check("sweep.err", 32'(err_o), 32'd0);

        // jump in the sequence gives exactly one error
        do_clear();
        check("clear.beats", beat_cnt_o, 32'd0);
        send_word(8'h00); send_word(8'h01); send_word(8'h02);
        send_word(8'h07); send_word(8'h08); send_word(8'h09);
        check("jump.beats", beat_cnt_o, 32'd6);
        check("jump.errs", 32'(err_cnt_o), 32'd1);
        check("jump.fdata", 32'(first_err_data_o), 32'h07);
        check("jump.fexp", 32'(first_err_exp_o), 32'h03);

        // alternate mode: one beat per two cycles
        do_clear();
        ready_mode_i = 2'd3;
        run(40, 100, 0, 0);
        check("alt.beats", beat_cnt_o, 32'd20);

        // never-ready mode
        ready_mode_i = 2'd1;
        step(1'b0, nxt, 1'b0, acc);
        run(100, 100, 0, 0);
        check("never.beats", beat_cnt_o, 32'd20);

        // LFSR-driven ready over 1000 cycles
        do_clear();
        ready_mode_i = 2'd2;
        run(1000, 100, 0, 0);
        check("lfsr.beats", beat_cnt_o, m_beats);
        check("lfsr.errs", 32'(err_cnt_o), 32'd0);

        // injected errors, then clear coincident with an accepted beat
        ready_mode_i = 2'd0;
        do_clear();
        for (int i = 0; i < 12; i++) begin
            if (i == 5 || i == 9) send_word(nxt ^ 8'h40);
            else send_word(nxt);
        end
        check("inj.err", 32'(err_o), 32'd1);
        check("inj.fexp", 32'(first_err_exp_o), 32'h05);
        step(1'b1, nxt, 1'b1, acc);
        check("coinc.acc", 32'(acc), 32'd1);
        check("coinc.beats", beat_cnt_o, 32'd0);
        check("coinc.errs", 32'(err_cnt_o), 32'd0);
        nxt = START;
        for (int i = 0; i < 20; i++) send_word(nxt);
        check("resume.beats", beat_cnt_o, 32'd20);
        check("resume.errs", 32'(err_cnt_o), 32'd0);

        // randomized mix of modes, gaps, corruptions and clears
        for (int blk = 0; blk < 12; blk++) begin
            ready_mode_i = 2'($urandom_range(3));
            run(50, 70, 5, 2);
        end

        // asynchronous reset between edges, mid-stream
        ready_mode_i = 2'd0;
        run(10, 100, 10, 0);
        #2 rst_clk_i = 1'b1;
        sb_reset();
        #1 check_all("async_rst");
        repeat (2) @(negedge clk_i);
        check_all("in_rst");
        rst_clk_i = 1'b0;
        nxt = START;
        for (int i = 0; i < 30; i++) send_word(nxt);
        check("restart.beats", beat_cnt_o, 32'd30);
        check("restart.errs", 32'(err_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
